// File: rtl/decode_rename_queue.sv
// 2-wide in / 2-wide out circular queue between Decode and Rename, with hole compaction and flush.
// Optional same-cycle empty-queue bypass is enabled by defining IQ_BYPASS_EN.
package uarch_pkg;
  localparam int PIPE_WIDTH = 2;

  typedef struct packed {
    logic        is_valid;
    logic [31:0] pc;
    logic [31:0] insn;
  } instruction_t;
endpackage

module decode_rename_queue #(
  parameter int DEPTH = 8
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              flush,
  input  uarch_pkg::instruction_t [uarch_pkg::PIPE_WIDTH-1:0] decoded_insts,
  output logic                                              iq_rdy,
  input  logic                                              rename_rdy,
  output uarch_pkg::instruction_t [uarch_pkg::PIPE_WIDTH-1:0] queued_insts,
  output logic [$clog2(DEPTH):0]                            occupancy
);
  import uarch_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ROOM2 = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0] CNT_TWO   = (AW+1)'(2);

  instruction_t  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
  logic [AW:0]   count_q, count_d;
  instruction_t  cmp0, cmp1;
  logic [1:0]    enq_n, enq_eff, deq_n;
  logic          wr_en, bypass_take;

  assign head_p1   = head_q + 1'b1;
  assign tail_p1   = tail_q + 1'b1;
  assign iq_rdy    = (count_q <= CNT_ROOM2);
  assign occupancy = count_q;

  // Pack valid decode slots from slot 0, preserving program order
  always_comb begin
    cmp0  = '0;
    cmp1  = '0;
    enq_n = 2'd0;
    case ({decoded_insts[1].is_valid, decoded_insts[0].is_valid})
      2'b01: begin cmp0 = decoded_insts[0]; enq_n = 2'd1; end
      2'b10: begin cmp0 = decoded_insts[1]; enq_n = 2'd1; end
      2'b11: begin cmp0 = decoded_insts[0]; cmp1 = decoded_insts[1]; enq_n = 2'd2; end
      default: ;
    endcase
  end

`ifdef IQ_BYPASS_EN
  assign bypass_take = (count_q == '0) && !flush && rename_rdy;
`else
  assign bypass_take = 1'b0;
`endif

  assign wr_en   = iq_rdy && !flush && !rst && !bypass_take;
  assign enq_eff = wr_en ? enq_n : 2'd0;

  always_comb begin
    deq_n = 2'd0;
    if (rename_rdy) begin
      if (count_q >= CNT_TWO) deq_n = 2'd2;
      else                    deq_n = count_q[1:0];
    end
  end

  always_comb begin
    queued_insts = '0;
    if (count_q != '0) begin
      queued_insts[0]          = mem_q[head_q];
      queued_insts[0].is_valid = 1'b1;
    end
    if (count_q >= CNT_TWO) begin
      queued_insts[1]          = mem_q[head_p1];
      queued_insts[1].is_valid = 1'b1;
    end
`ifdef IQ_BYPASS_EN
    if (count_q == '0 && !flush) begin
      queued_insts[0] = cmp0;
      queued_insts[1] = cmp1;
    end
`endif
  end

  assign head_d  = head_q + AW'(deq_n);
  assign tail_d  = tail_q + AW'(enq_eff);
  assign count_d = count_q + (AW+1)'(enq_eff) - (AW+1)'(deq_n);

  // Control state: rst beats flush beats normal update
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_eff != 2'd0) mem_q[tail_q]  <= cmp0;
    if (enq_eff == 2'd2) mem_q[tail_p1] <= cmp1;
  end

endmodule

// File: tb/tb_decode_rename_queue.sv
// Directed bench for decode_rename_queue (DEPTH=8): reset, compaction, flush, fill, wrap, bypass/latency.
module tb_decode_rename_queue;
  import uarch_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, rename_rdy, iq_rdy;
  instruction_t [1:0] decoded_insts, queued_insts;
  logic [3:0] occupancy;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_rename_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .decoded_insts(decoded_insts),
    .iq_rdy(iq_rdy), .rename_rdy(rename_rdy), .queued_insts(queued_insts),
    .occupancy(occupancy)
  );

  function automatic instruction_t mk(bit v, logic [31:0] pc);
    instruction_t r;
    r.is_valid = v;
    r.pc       = pc;
    r.insn     = pc ^ 32'hA5A5_0000;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v0, logic [31:0] p0, bit v1, logic [31:0] p1);
    decoded_insts[0] = mk(v0, p0);
    decoded_insts[1] = mk(v1, p1);
  endtask

  task automatic idle_in();
    drive(1'b0, 32'hDEAD_0000, 1'b0, 32'hDEAD_0004);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; rename_rdy = 1'b1; idle_in();
    step(); step();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    checks++; if (iq_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", iq_rdy); end
    checks++; if (queued_insts !== '0) begin errors++; $display("FAIL reset_out got %h want 0", queued_insts); end
    rst = 1'b0;
    step(); step();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL idle_occ got %0d want 0", occupancy); end
    checks++; if (queued_insts !== '0) begin errors++; $display("FAIL idle_out got %h want 0", queued_insts); end
  endtask

  task automatic test_compaction();
    rename_rdy = 1'b0;
    drive(1'b0, 32'hDEAD_0100, 1'b1, 32'h104);
    step();
    idle_in();
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL cmp_occ1 got %0d want 1", occupancy); end
    checks++; if (queued_insts[0] !== mk(1'b1, 32'h104)) begin errors++; $display("FAIL cmp_slot0a got %h want pc 104", queued_insts[0]); end
    checks++; if (queued_insts[1] !== '0) begin errors++; $display("FAIL cmp_slot1a got %h want 0", queued_insts[1]); end
    drive(1'b1, 32'h108, 1'b1, 32'h10C);
    step();
    idle_in();
    checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL cmp_occ3 got %0d want 3", occupancy); end
    checks++; if (queued_insts[0] !== mk(1'b1, 32'h104)) begin errors++; $display("FAIL cmp_slot0 got %h want pc 104", queued_insts[0]); end
    checks++; if (queued_insts[1] !== mk(1'b1, 32'h108)) begin errors++; $display("FAIL cmp_slot1 got %h want pc 108", queued_insts[1]); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h110, 1'b1, 32'h114);
    step();
    checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL fl_pre got %0d want 5", occupancy); end
    drive(1'b1, 32'h300, 1'b1, 32'h304);
    flush = 1'b1; rename_rdy = 1'b1;
    step();
    flush = 1'b0; idle_in();
    #1;
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL fl_occ got %0d want 0", occupancy); end
    checks++; if (queued_insts !== '0) begin errors++; $display("FAIL fl_out got %h want 0", queued_insts); end
    checks++; if (iq_rdy !== 1'b1) begin errors++; $display("FAIL fl_rdy got %b want 1", iq_rdy); end
    step();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL fl_absent got %0d want 0", occupancy); end
  endtask

  task automatic test_fill();
    rename_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400 + 32'(8*i), 1'b1, 32'h404 + 32'(8*i));
      step();
      checks++; if (occupancy !== 4'(2*i+2)) begin errors++; $display("FAIL fill_occ%0d got %0d want %0d", i, occupancy, 2*i+2); end
      checks++; if (iq_rdy !== 1'b1) begin errors++; $display("FAIL fill_rdy%0d got %b want 1", i, iq_rdy); end
    end
    drive(1'b1, 32'h418, 1'b0, 32'hDEAD_041C);
    step();
    checks++; if (occupancy !== 4'd7) begin errors++; $display("FAIL fill_occ7 got %0d want 7", occupancy); end
    checks++; if (iq_rdy !== 1'b0) begin errors++; $display("FAIL fill_rdy7 got %b want 0", iq_rdy); end
    drive(1'b1, 32'h500, 1'b1, 32'h504);
    step(); step();
    checks++; if (occupancy !== 4'd7) begin errors++; $display("FAIL fill_hold got %0d want 7", occupancy); end
    checks++; if (queued_insts[0] !== mk(1'b1, 32'h400) || queued_insts[1] !== mk(1'b1, 32'h404)) begin
      errors++; $display("FAIL fill_out got %h want pcs 400/404", queued_insts); end
    drive(1'b1, 32'h501, 1'b0, 32'hDEAD_0505);
    step();
    checks++; if (occupancy !== 4'd7) begin errors++; $display("FAIL fill_single got %0d want 7", occupancy); end
    idle_in();
  endtask

  task automatic test_wrap();
    // head 0, count 7: drain three pairs to reach head 6, count 1
    rename_rdy = 1'b1;
    step(); step(); step();
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL wr_drain got %0d want 1", occupancy); end
    checks++; if (queued_insts[0] !== mk(1'b1, 32'h418)) begin errors++; $display("FAIL wr_e6 got %h want pc 418", queued_insts[0]); end
    drive(1'b1, 32'h600, 1'b0, 32'hDEAD_0000);
    step();
    rename_rdy = 1'b0;
    drive(1'b0, 32'hDEAD_0000, 1'b1, 32'h604);
    step();
    idle_in();
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL wr_pre got %0d want 2", occupancy); end
    checks++; if (queued_insts[0] !== mk(1'b1, 32'h600)) begin errors++; $display("FAIL wr_e7 got %h want pc 600", queued_insts[0]); end
    checks++; if (queued_insts[1] !== mk(1'b1, 32'h604)) begin errors++; $display("FAIL wr_e0 got %h want pc 604", queued_insts[1]); end
    drive(1'b1, 32'h608, 1'b1, 32'h60C);
    rename_rdy = 1'b1;
    step();
    idle_in(); rename_rdy = 1'b0;
    #1;
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL wr_occ got %0d want 2", occupancy); end
    checks++; if (queued_insts[0] !== mk(1'b1, 32'h608)) begin errors++; $display("FAIL wr_new0 got %h want pc 608", queued_insts[0]); end
    checks++; if (queued_insts[1] !== mk(1'b1, 32'h60C)) begin errors++; $display("FAIL wr_new1 got %h want pc 60C", queued_insts[1]); end
    rename_rdy = 1'b1;
    step();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL wr_empty got %0d want 0", occupancy); end
    step();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL wr_rdy_ignored got %0d want 0", occupancy); end
  endtask

  task automatic test_latency();
    rename_rdy = 1'b1;
    drive(1'b1, 32'h200, 1'b1, 32'h204);
    #1;
`ifdef IQ_BYPASS_EN
    checks++; if (queued_insts[0] !== mk(1'b1, 32'h200) || queued_insts[1] !== mk(1'b1, 32'h204)) begin
      errors++; $display("FAIL byp_out got %h want pcs 200/204", queued_insts); end
    step();
    idle_in();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL byp_occ got %0d want 0", occupancy); end
    rename_rdy = 1'b0;
    drive(1'b1, 32'h200, 1'b1, 32'h204);
    step();
    idle_in();
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL byp_enq got %0d want 2", occupancy); end
`else
    checks++; if (queued_insts !== '0) begin errors++; $display("FAIL lat_same got %h want 0", queued_insts); end
    step();
    idle_in();
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL lat_occ got %0d want 2", occupancy); end
    checks++; if (queued_insts[0] !== mk(1'b1, 32'h200) || queued_insts[1] !== mk(1'b1, 32'h204)) begin
      errors++; $display("FAIL lat_out got %h want pcs 200/204", queued_insts); end
    step();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL lat_deq got %0d want 0", occupancy); end
`endif
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; rename_rdy = 1'b0;
    decoded_insts = '0;
    test_reset();
    test_compaction();
    test_flush();
    test_fill();
    test_wrap();
    test_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_rename_queue.md
Name: decode_rename_queue

Overview:
- 2-wide in / 2-wide out circular instruction queue between Decode and Rename.
- Decouples Decode from Rename backpressure. Rename stalls whenever dispatch is not ready or ROB allocation is not fully granted.
- Compacts holes in the decode bundle so Rename always sees valid instructions packed from slot 0, in program order.
- Discards all contents on pipeline flush.

Parameters:
- DEPTH, 8, number of instruction entries. Power of two, must be >= 4.
- PIPE_WIDTH, 2 (from uarch_pkg), bundle width. The block is fixed at 2.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  pipeline flush (mispredict/exception).
- decoded_insts  input  instruction_t x PIPE_WIDTH  decode bundle; per-slot is_valid.
- iq_rdy  output  1  queue can accept a full bundle this cycle.
- rename_rdy  input  1  Rename consumes every valid slot presented this cycle.
- queued_insts  output  instruction_t x PIPE_WIDTH  bundle presented to Rename, packed from slot 0.
- occupancy  output  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Storage:
  - DEPTH-entry array.
  - head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register, $clog2(DEPTH)+1 bits, range 0..DEPTH. occupancy = count.
- Reset (rst=1 at posedge):
  - head=tail=count=0.
  - Entry contents are don't-care.
  - queued_insts slots all '0 (is_valid=0) from the next cycle.
  - iq_rdy=1.
- Enqueue:
  - iq_rdy = (DEPTH - count) >= 2. Combinational from count only; independent of rename_rdy and decode validity.
  - Enqueue fires when iq_rdy && !flush && !rst.
  - Valid slots are written at tail in order: slot0 first, then slot1.
  - A bundle {invalid, valid} writes slot1's instruction at tail (compaction).
  - enq_n = number of valid slots (0..2). tail advances by enq_n.
  - Decode bundles presented while iq_rdy=0 are not written. Decode must hold them.
- Dequeue:
  - queued_insts[0] = entry[head], is_valid forced to (count>=1).
  - queued_insts[1] = entry[head+1 mod DEPTH], is_valid forced to (count>=2).
  - Any slot with is_valid=0 drives '0 on all fields.
  - Output is combinational from registered state: zero-cycle read, one-cycle write-to-visible latency.
  - When rename_rdy=1, deq_n = number of valid output slots. head advances by deq_n.
  - Rename consumes all or nothing; there is no partial dequeue.
- Count update: count_next = count + enq_n - deq_n. Simultaneous enqueue and dequeue is legal in every state, including full-minus-2 and empty.
- Boundaries:
  - count=DEPTH-1: iq_rdy=0 even if only one slot is valid.
  - count=0: queued_insts all invalid, and rename_rdy is ignored.
  - Pointer wrap: head+1 and tail+1 computed modulo DEPTH. Entry DEPTH-1 followed by entry 0 must appear as slots 0/1 correctly.
- Flush:
  - flush=1 at posedge sets head=tail=count=0.
  - Overrides same-cycle enqueue and dequeue; the incoming bundle is dropped.
  - Outputs are invalid in the following cycle.
- Priority: rst > flush > enqueue/dequeue.
- Ordering: strict program order is maintained. slot0 of an output bundle is always older than slot1.

Optional Feature:
- Macro: IQ_BYPASS_EN.
- Defined, when count==0 and !flush:
  - queued_insts is driven combinationally from the compacted decoded_insts.
  - If rename_rdy=1 that cycle, the bypassed instructions are consumed and not written; count stays 0.
  - If rename_rdy=0, they are enqueued normally.
  - iq_rdy is unchanged.
- Undefined: no bypass. Minimum decode-to-rename latency is 1 cycle.

Test Plan:
- Reset/empty:
  - Stimulus: rst=1 for 2 cycles, then idle with rename_rdy=1.
  - Required: occupancy=0, iq_rdy=1, both queued_insts.is_valid=0, head unchanged.
- Compaction:
  - Stimulus: enqueue {invalid, pc=0x104}, then {pc=0x108, pc=0x10C} with rename_rdy=0.
  - Required: occupancy=3; output slot0 pc=0x104, slot1 pc=0x108.
- Fill/backpressure (DEPTH=8):
  - Stimulus: enqueue 3 full bundles with rename_rdy=0, then 1 single-valid bundle.
  - Required: occupancy=7 and iq_rdy=0. A further bundle is not written; occupancy stays 7.
- Simultaneous enqueue/dequeue with wrap:
  - Stimulus: preload so head=7, count=2; enqueue 2 valid with rename_rdy=1.
  - Required: outputs are entry7 then entry0; next cycle head=1, count=2, outputs are the new pair in order.
- Flush mid-operation:
  - Stimulus: count=5; assert flush together with a valid enqueue and rename_rdy=1.
  - Required: next cycle count=0, outputs invalid, and the flushed-cycle bundle is absent.
- Bypass (IQ_BYPASS_EN defined):
  - Stimulus: empty queue; present {pc=0x200, pc=0x204} with rename_rdy=1.
  - Required: same-cycle outputs pc=0x200/0x204, occupancy stays 0.
  - Stimulus variant: same bundle with rename_rdy=0.
  - Required: occupancy=2 next cycle.
